// File: rtl/count_capture_fifo.sv
// Extends an incoming counter value with a wrap epoch and logs {epoch, count} words into a FWFT FIFO.
// Define AUTO_CAPTURE_EN to make every wrap pulse also log a word.
module count_capture_fifo #(
  parameter int SIZE    = 4,
  parameter int EPOCH_W = 4,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SIZE-1:0]            count,
  input  logic                       pulse,
  input  logic                       up_down,
  input  logic                       capture,
  input  logic                       rd_ready,
  input  logic                       clr_ovf,
  output logic                       rd_valid,
  output logic [EPOCH_W+SIZE-1:0]    rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       overflow
);

  localparam int W     = EPOCH_W + SIZE;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(DEPTH-1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 ovf_q, ovf_d;
  logic [W-1:0]         mem_q [DEPTH];
  logic [W-1:0]         mem_d [DEPTH];

  logic wr_req;
  logic pop;
  logic push;
  logic drop;

  // Handshake decode. A full FIFO still accepts a write when the head pops in the same cycle.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
`ifdef AUTO_CAPTURE_EN
    wr_req = capture | pulse;
`else
    wr_req = capture;
`endif
    pop  = rd_valid & rd_ready;
    push = wr_req & (~full | pop);
    drop = wr_req & full & ~pop;
  end

  // Datapath next values. The stored epoch is always the pre-update value.
  always_comb begin
    epoch_d = epoch_q;
    if (pulse) begin
      epoch_d = up_down ? epoch_q + EPOCH_ONE : epoch_q - EPOCH_ONE;
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // A dropped write outranks a clear in the same cycle.
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {epoch_q, count};
    end
  end

  // Next-state logic: occupancy class follows the level counter.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (push && !pop && level_q == LVL_LAST) begin
          state_d = ST_FULL;
        end else if (pop && !push && level_q == LVL_ONE) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop && !push) state_d = ST_PARTIAL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    rd_valid = (state_q != ST_EMPTY);
    full     = (state_q == ST_FULL);
    level    = level_q;
    overflow = ovf_q;
    rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      epoch_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      epoch_q  <= epoch_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is not reset; rd_data is masked while empty, so stale words never escape.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
